wb_i2c_cmd_sequencer: RTL and testbench
=======================================

WB_I2C_CMD_SEQUENCER -- requirements
Module: wb_i2c_cmd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535, max clk_i cycles spent waiting for irq_i per byte-level command.
REQ-002 SHALL have parameter TO_W, default 16, width of the timeout counter; TIMEOUT_CYCLES SHALL fit in TO_W bits.
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid_i  input  1  host command request.
REQ-006 cmd_ready_o  output  1  sequencer accepts a command.
REQ-007 cmd_op_i  input  3  0 ENABLE, 1 SET_BUS, 2 START, 3 STOP, 4 WRITE, 5 READ_ACK, 6 READ_NAK, 7 WAIT.
REQ-008 cmd_data_i  input  8  write byte / bus id / wait count.
REQ-009 rsp_valid_o  output  1  response available.
REQ-010 rsp_ready_i  input  1  host consumes response.
REQ-011 rsp_status_o  output  2  0 DONE, 1 NAK, 2 ARB_LOST, 3 ERROR.
REQ-012 rsp_data_o  output  8  read byte; 0x00 for non-read or failed ops.
REQ-013 cyc_o, stb_o, we_o  output  1 each  Wishbone master strobes.
REQ-014 adr_o  output  2  register address: 0 CSR, 1 DPR, 2 CMDR, 3 FSMR.
REQ-015 dat_o  output  8  Wishbone write data.
REQ-016 dat_i  input  8  Wishbone read data.
REQ-017 ack_i  input  1  Wishbone acknowledge.
REQ-018 irq_i  input  1  core interrupt, level, cleared by CMDR read.

Function
REQ-019 Command accepted on cycle where cmd_valid_i && cmd_ready_o; op and data SHALL be latched then.
REQ-020 cmd_ready_o SHALL be 1 only in state IDLE; cmd_valid_i outside IDLE is ignored.
REQ-021 States: IDLE, WR_CSR, WR_DPR, WR_CMDR, WAIT_IRQ, RD_CMDR, RD_DPR, RESP.
REQ-022 Sequences: ENABLE: WR_CSR(0xC0) -> RESP DONE; SET_BUS: WR_DPR(data) -> WR_CMDR(0x06); START: WR_CMDR(0x04); STOP: WR_CMDR(0x05); WRITE: WR_DPR(data) -> WR_CMDR(0x01); READ_ACK: WR_CMDR(0x02); READ_NAK: WR_CMDR(0x03); WAIT: WR_DPR(data) -> WR_CMDR(0x00).
REQ-023 Every WR_CMDR SHALL be followed by WAIT_IRQ -> RD_CMDR.
REQ-024 Each bus access: cyc_o=stb_o=1 with adr_o/we_o/dat_o stable until the cycle ack_i=1; cyc_o=stb_o=0 the next cycle; state advances on the ack cycle.
REQ-025 At most one Wishbone access outstanding; cyc_o and stb_o SHALL always be equal.
REQ-026 WAIT_IRQ: counter cleared on entry, increments each cycle irq_i=0; irq_i=1 -> RD_CMDR; counter reaching TIMEOUT_CYCLES -> RESP with ERROR, no CMDR read.
REQ-027 RD_CMDR status decode from dat_i on ack, priority: bit4 ERR -> ERROR, bit5 AL -> ARB_LOST, bit6 NAK -> NAK, bit7 DON -> DONE; none set -> ERROR.
REQ-028 READ_ACK/READ_NAK with status DONE SHALL perform RD_DPR and return dat_i as rsp_data_o; otherwise go to RESP directly, rsp_data_o=0x00.
REQ-029 RESP: rsp_valid_o=1, rsp_status_o/rsp_data_o stable until rsp_ready_i=1; on that cycle -> IDLE, rsp_valid_o=0 next cycle.
REQ-030 Minimum latency ENABLE: accept cycle +1 to bus request; ack on first cycle gives rsp_valid_o 2 cycles after accept.
REQ-031 ack_i outside an active cycle SHALL be ignored; irq_i outside WAIT_IRQ SHALL be ignored.

Reset
REQ-032 rst_i=1 at a clock edge SHALL force IDLE, cyc_o=stb_o=we_o=0, adr_o=0, dat_o=0x00, rsp_valid_o=0, rsp_status_o=0, rsp_data_o=0x00, cmd_ready_o=1 after release, timeout counter 0.
REQ-033 Reset mid-transfer SHALL drop cyc_o/stb_o on the edge rst_i is sampled; no response issued for the aborted command.

Verification
REQ-034 ENABLE, ack after 1 cycle -> one write adr 0 dat 0xC0, rsp DONE, data 0x00.
REQ-035 WRITE 0xA5, slave irq 10 cycles later, CMDR reads 0x80 -> writes DPR 0xA5 then CMDR 0x01, rsp DONE.
REQ-036 READ_ACK, CMDR reads 0x80, DPR reads 0x3C -> CMDR 0x02 written, rsp DONE data 0x3C.
REQ-037 WRITE, CMDR reads 0xC0 -> rsp NAK, no DPR read; CMDR 0xA0 -> ARB_LOST; CMDR 0x90 -> ERROR.
REQ-038 START with TIMEOUT_CYCLES=20, irq_i held 0 -> rsp ERROR 20 cycles after WAIT_IRQ entry, no CMDR read.
REQ-039 rst_i asserted during WAIT_IRQ with rsp_ready_i=0 stalls -> cyc_o=0, IDLE, cmd_ready_o=1, no rsp_valid_o pulse.

Source files
------------

// File: rtl/wb_i2c_cmd_sequencer.sv
// Turns byte-level I2C host commands into Wishbone register accesses on an
// I2C master core, waits for its interrupt, and reports a decoded status.
module wb_i2c_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned TO_W           = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [2:0] cmd_op_i,
  input  logic [7:0] cmd_data_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [1:0] rsp_status_o,
  output logic [7:0] rsp_data_o,
  output logic       cyc_o,
  output logic       stb_o,
  output logic       we_o,
  output logic [1:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i,
  input  logic       irq_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_CSR, S_WR_DPR, S_WR_CMDR, S_WAIT_IRQ, S_RD_CMDR, S_RD_DPR, S_RESP
  } state_t;

  localparam logic [2:0] OP_ENABLE   = 3'd0;
  localparam logic [2:0] OP_SET_BUS  = 3'd1;
  localparam logic [2:0] OP_START    = 3'd2;
  localparam logic [2:0] OP_STOP     = 3'd3;
  localparam logic [2:0] OP_WRITE    = 3'd4;
  localparam logic [2:0] OP_READ_ACK = 3'd5;
  localparam logic [2:0] OP_READ_NAK = 3'd6;
  localparam logic [2:0] OP_WAIT     = 3'd7;

  localparam logic [1:0] ST_DONE     = 2'd0;
  localparam logic [1:0] ST_NAK      = 2'd1;
  localparam logic [1:0] ST_ARB_LOST = 2'd2;
  localparam logic [1:0] ST_ERROR    = 2'd3;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [7:0]      data_q, data_d;
  logic            cyc_q, cyc_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]      st_q, st_d;
  logic [7:0]      rd_q, rd_d;
  logic [7:0]      cmdr_code;
  logic [1:0]      cmdr_status;
  logic            is_read_op;

  always_comb begin
    cmdr_code = 8'h00;
    case (op_q)
      OP_SET_BUS:  cmdr_code = 8'h06;
      OP_START:    cmdr_code = 8'h04;
      OP_STOP:     cmdr_code = 8'h05;
      OP_WRITE:    cmdr_code = 8'h01;
      OP_READ_ACK: cmdr_code = 8'h02;
      OP_READ_NAK: cmdr_code = 8'h03;
      default:     cmdr_code = 8'h00;
    endcase
  end

  // CMDR status bits, highest severity first; no bit set is treated as an error.
  always_comb begin
    cmdr_status = ST_ERROR;
    if (dat_i[4])      cmdr_status = ST_ERROR;
    else if (dat_i[5]) cmdr_status = ST_ARB_LOST;
    else if (dat_i[6]) cmdr_status = ST_NAK;
    else if (dat_i[7]) cmdr_status = ST_DONE;
  end

  assign is_read_op = (op_q == OP_READ_ACK) || (op_q == OP_READ_NAK);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    cyc_d    = cyc_q;
    to_cnt_d = to_cnt_q;
    st_d     = st_q;
    rd_d     = rd_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d   = cmd_op_i;
          data_d = cmd_data_i;
          st_d   = ST_DONE;
          rd_d   = 8'h00;
          cyc_d  = 1'b1;
          case (cmd_op_i)
            OP_ENABLE:                     state_d = S_WR_CSR;
            OP_SET_BUS, OP_WRITE, OP_WAIT: state_d = S_WR_DPR;
            default:                       state_d = S_WR_CMDR;
          endcase
        end
      end
      // A bus state entered straight off an ack spends one idle cycle first,
      // so cyc_o always drops for a cycle between back-to-back accesses.
      S_WR_CSR, S_WR_DPR, S_WR_CMDR, S_RD_CMDR, S_RD_DPR: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
        end else if (ack_i) begin
          cyc_d = 1'b0;
          case (state_q)
            S_WR_CSR: state_d = S_RESP;
            S_WR_DPR: state_d = S_WR_CMDR;
            S_WR_CMDR: begin
              state_d  = S_WAIT_IRQ;
              to_cnt_d = '0;
            end
            S_RD_CMDR: begin
              st_d    = cmdr_status;
              state_d = (is_read_op && cmdr_status == ST_DONE) ? S_RD_DPR : S_RESP;
            end
            S_RD_DPR: begin
              rd_d    = dat_i;
              state_d = S_RESP;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_WAIT_IRQ: begin
        if (irq_i) begin
          state_d = S_RD_CMDR;
          cyc_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_d == TO_LIMIT) begin
            state_d = S_RESP;
            st_d    = ST_ERROR;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      data_q   <= 8'h00;
      cyc_q    <= 1'b0;
      to_cnt_q <= '0;
      st_q     <= 2'd0;
      rd_q     <= 8'h00;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      cyc_q    <= cyc_d;
      to_cnt_q <= to_cnt_d;
      st_q     <= st_d;
      rd_q     <= rd_d;
    end
  end

  // Address and data are qualified by cyc so the bus is quiet between accesses.
  always_comb begin
    adr_o = 2'd0;
    we_o  = 1'b0;
    dat_o = 8'h00;
    if (cyc_q) begin
      case (state_q)
        S_WR_CSR:  begin adr_o = 2'd0; we_o = 1'b1; dat_o = 8'hC0;     end
        S_WR_DPR:  begin adr_o = 2'd1; we_o = 1'b1; dat_o = data_q;    end
        S_WR_CMDR: begin adr_o = 2'd2; we_o = 1'b1; dat_o = cmdr_code; end
        S_RD_CMDR: adr_o = 2'd2;
        S_RD_DPR:  adr_o = 2'd1;
        default:   adr_o = 2'd0;
      endcase
    end
  end

  assign cyc_o        = cyc_q;
  assign stb_o        = cyc_q;
  assign cmd_ready_o  = (state_q == S_IDLE);
  assign rsp_valid_o  = (state_q == S_RESP);
  assign rsp_status_o = st_q;
  assign rsp_data_o   = rd_q;

endmodule

// File: tb/tb_wb_i2c_cmd_sequencer.sv
// Directed bench: a behavioural Wishbone/IRQ slave logs every access while a
// vector table of commands and hand sequences checks responses and bus traffic.
module tb_wb_i2c_cmd_sequencer;

  localparam logic [2:0] OP_ENABLE   = 3'd0;
  localparam logic [2:0] OP_SET_BUS  = 3'd1;
  localparam logic [2:0] OP_START    = 3'd2;
  localparam logic [2:0] OP_STOP     = 3'd3;
  localparam logic [2:0] OP_WRITE    = 3'd4;
  localparam logic [2:0] OP_READ_ACK = 3'd5;
  localparam logic [2:0] OP_READ_NAK = 3'd6;
  localparam logic [2:0] OP_WAIT     = 3'd7;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic [2:0] cmd_op_i = 3'd0;
  logic [7:0] cmd_data_i = 8'h00;
  logic       rsp_valid_o;
  logic       rsp_ready_i = 1'b0;
  logic [1:0] rsp_status_o;
  logic [7:0] rsp_data_o;
  logic       cyc_o, stb_o, we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i = 8'h00;
  logic       ack_i = 1'b0;
  logic       irq_i = 1'b0;

  wb_i2c_cmd_sequencer #(.TIMEOUT_CYCLES(20), .TO_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_status_o(rsp_status_o), .rsp_data_o(rsp_data_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
    .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_total = 0;
  int n_pass  = 0;

  // slave configuration and access log
  int         ack_wait = 0;
  int         irq_delay = 0;
  logic [7:0] cmdr_val = 8'h80;
  logic [7:0] dpr_val = 8'h00;
  int         wcnt = 0;
  bit         in_acc = 0;
  bit         prev_ack = 0;
  logic [1:0] acc_adr;
  logic [7:0] acc_dat;
  logic       acc_we;
  bit         irq_armed = 0;
  int         irq_cnt = 0;
  int         viol = 0;
  int         csr_n, dpr_n, cmdr_n, crd_n, drd_n;
  logic [7:0] csr_d, dpr_d, cmdr_d;
  int         cmdr_at = 0;
  int         rsp_at = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    int         ack_wait;
    int         irq_delay;
    logic [7:0] cmdr_val;
    logic [7:0] dpr_val;
    int         stall;
    logic [1:0] exp_st;
    logic [7:0] exp_dt;
    int         exp_csr_n;
    logic [7:0] exp_csr_d;
    int         exp_dpr_n;
    logic [7:0] exp_dpr_d;
    int         exp_cmdr_n;
    logic [7:0] exp_cmdr_d;
    int         exp_crd_n;
    int         exp_drd_n;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_log();
    csr_n = 0; dpr_n = 0; cmdr_n = 0; crd_n = 0; drd_n = 0;
    csr_d = 8'h00; dpr_d = 8'h00; cmdr_d = 8'h00;
    viol = 0;
  endtask

  // Runs once per negedge: protocol checks, irq model, and ack/data response.
  task automatic slave_step();
    if (cyc_o !== stb_o) viol++;
    if (prev_ack && cyc_o) viol++;
    if (irq_armed) begin
      if (irq_cnt == 0) irq_i = 1'b1;
      else irq_cnt--;
    end
    ack_i = 1'b0;
    dat_i = 8'h00;
    if (cyc_o) begin
      if (!in_acc) begin
        in_acc = 1; acc_adr = adr_o; acc_dat = dat_o; acc_we = we_o;
      end else if ({adr_o, dat_o, we_o} !== {acc_adr, acc_dat, acc_we}) begin
        viol++;
      end
      if (wcnt == ack_wait) begin
        ack_i = 1'b1; in_acc = 0; wcnt = 0;
        if (we_o) begin
          case (adr_o)
            2'd0: begin csr_n++; csr_d = dat_o; end
            2'd1: begin dpr_n++; dpr_d = dat_o; end
            2'd2: begin
              cmdr_n++; cmdr_d = dat_o; cmdr_at = cyc_cnt;
              if (irq_delay >= 0) begin irq_armed = 1; irq_cnt = irq_delay; end
            end
            default: viol++;
          endcase
        end else begin
          case (adr_o)
            2'd2: begin crd_n++; dat_i = cmdr_val; irq_i = 1'b0; irq_armed = 0; end
            2'd1: begin drd_n++; dat_i = dpr_val; end
            default: viol++;
          endcase
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0; in_acc = 0;
    end
    prev_ack = ack_i;
  endtask

  task automatic tick();
    @(negedge clk);
    slave_step();
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [7:0] data, input int stall,
                        input string tag, output logic [1:0] st, output logic [7:0] dt);
    int n;
    st = 2'd0; dt = 8'h00;
    n = 0;
    while (!cmd_ready_o && n < 50) begin tick(); n++; end
    cmd_op_i = op; cmd_data_i = data; cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    n = 0;
    while (!rsp_valid_o && n < 300) begin tick(); n++; end
    if (!rsp_valid_o) begin
      chk({tag, " rsp_timeout"}, 32'd0, 32'd1);
    end else begin
      rsp_at = cyc_cnt;
      st = rsp_status_o; dt = rsp_data_o;
      for (int i = 0; i < stall; i++) begin
        tick();
        if (!rsp_valid_o || rsp_status_o !== st || rsp_data_o !== dt) viol++;
      end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      chk({tag, " rsp_drop"}, 32'(rsp_valid_o), 32'd0);
    end
  endtask

  initial begin
    logic [1:0] st;
    logic [7:0] dt;
    int         seen;

    //         op           data   ackw irq  cmdr   dpr    stl st    dt     csr   csr_d  dpr dpr_d  cmd cmd_d  crd drd
    vecs[0]  = '{OP_ENABLE,   8'h00, 1,   5,  8'h80, 8'h00, 0, 2'd0, 8'h00, 1, 8'hC0, 0, 8'h00, 0, 8'h00, 0, 0};
    vecs[1]  = '{OP_WRITE,    8'hA5, 0,  10,  8'h80, 8'h00, 2, 2'd0, 8'h00, 0, 8'h00, 1, 8'hA5, 1, 8'h01, 1, 0};
    vecs[2]  = '{OP_READ_ACK, 8'h00, 0,   3,  8'h80, 8'h3C, 0, 2'd0, 8'h3C, 0, 8'h00, 0, 8'h00, 1, 8'h02, 1, 1};
    vecs[3]  = '{OP_WRITE,    8'h11, 1,   2,  8'hC0, 8'h55, 0, 2'd1, 8'h00, 0, 8'h00, 1, 8'h11, 1, 8'h01, 1, 0};
    vecs[4]  = '{OP_WRITE,    8'h22, 0,   2,  8'hA0, 8'h55, 0, 2'd2, 8'h00, 0, 8'h00, 1, 8'h22, 1, 8'h01, 1, 0};
    vecs[5]  = '{OP_WRITE,    8'h33, 0,   2,  8'h90, 8'h55, 1, 2'd3, 8'h00, 0, 8'h00, 1, 8'h33, 1, 8'h01, 1, 0};
    vecs[6]  = '{OP_READ_NAK, 8'h00, 0,   4,  8'h00, 8'h55, 0, 2'd3, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'h03, 1, 0};
    vecs[7]  = '{OP_SET_BUS,  8'h05, 0,   1,  8'h80, 8'h00, 0, 2'd0, 8'h00, 0, 8'h00, 1, 8'h05, 1, 8'h06, 1, 0};
    vecs[8]  = '{OP_START,    8'h00, 2,   0,  8'h80, 8'h00, 0, 2'd0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'h04, 1, 0};
    vecs[9]  = '{OP_STOP,     8'h00, 0,   6,  8'h80, 8'h00, 0, 2'd0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'h05, 1, 0};
    vecs[10] = '{OP_WAIT,     8'h07, 0,   2,  8'h80, 8'h00, 0, 2'd0, 8'h00, 0, 8'h00, 1, 8'h07, 1, 8'h00, 1, 0};
    vecs[11] = '{OP_READ_NAK, 8'h00, 2,   1,  8'h80, 8'hE1, 3, 2'd0, 8'hE1, 0, 8'h00, 0, 8'h00, 1, 8'h03, 1, 1};
    vecs[12] = '{OP_READ_ACK, 8'h00, 0,   2,  8'hE0, 8'h77, 0, 2'd2, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'h02, 1, 0};
    vecs[13] = '{OP_READ_ACK, 8'h00, 0,   2,  8'hF0, 8'h77, 0, 2'd3, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'h02, 1, 0};
    vecs[14] = '{OP_START,    8'h00, 0,  -1,  8'h80, 8'h00, 1, 2'd3, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'h04, 0, 0};

    clear_log();
    rst_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    chk("reset cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("reset cyc", 32'(cyc_o), 32'd0);
    chk("reset stb", 32'(stb_o), 32'd0);
    chk("reset we", 32'(we_o), 32'd0);
    chk("reset adr", 32'(adr_o), 32'd0);
    chk("reset dat", 32'(dat_o), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("reset rsp_status", 32'(rsp_status_o), 32'd0);
    chk("reset rsp_data", 32'(rsp_data_o), 32'd0);

    // stray ack/irq while idle must not start anything
    ack_i = 1'b1; irq_i = 1'b1;
    @(negedge clk);
    irq_i = 1'b0;
    slave_step();
    tick();
    chk("stray idle", {30'd0, cmd_ready_o, rsp_valid_o}, 32'd2);
    $display("stray ack/irq in idle: cmd_ready=%0d rsp_valid=%0d", cmd_ready_o, rsp_valid_o);

    for (int i = 0; i < 15; i++) begin
      ack_wait = vecs[i].ack_wait; irq_delay = vecs[i].irq_delay;
      cmdr_val = vecs[i].cmdr_val; dpr_val = vecs[i].dpr_val;
      clear_log();
      do_cmd(vecs[i].op, vecs[i].data, vecs[i].stall, $sformatf("v%0d", i), st, dt);
      $display("vec %0d op=%0d data=%02h -> status=%0d data=%02h csr=%0d dpr_wr=%0d cmdr_wr=%0d(%02h) cmdr_rd=%0d dpr_rd=%0d",
               i, vecs[i].op, vecs[i].data, st, dt, csr_n, dpr_n, cmdr_n, cmdr_d, crd_n, drd_n);
      chk($sformatf("v%0d status", i), 32'(st), 32'(vecs[i].exp_st));
      chk($sformatf("v%0d data", i), 32'(dt), 32'(vecs[i].exp_dt));
      chk($sformatf("v%0d csr_wr_n", i), csr_n, vecs[i].exp_csr_n);
      chk($sformatf("v%0d csr_wr_d", i), 32'(csr_d), 32'(vecs[i].exp_csr_d));
      chk($sformatf("v%0d dpr_wr_n", i), dpr_n, vecs[i].exp_dpr_n);
      chk($sformatf("v%0d dpr_wr_d", i), 32'(dpr_d), 32'(vecs[i].exp_dpr_d));
      chk($sformatf("v%0d cmdr_wr_n", i), cmdr_n, vecs[i].exp_cmdr_n);
      chk($sformatf("v%0d cmdr_wr_d", i), 32'(cmdr_d), 32'(vecs[i].exp_cmdr_d));
      chk($sformatf("v%0d cmdr_rd_n", i), crd_n, vecs[i].exp_crd_n);
      chk($sformatf("v%0d dpr_rd_n", i), drd_n, vecs[i].exp_drd_n);
      chk($sformatf("v%0d protocol", i), viol, 0);
    end

    // ENABLE minimum latency: bus request one cycle after accept, response one later
    ack_wait = 0; clear_log();
    cmd_op_i = OP_ENABLE; cmd_data_i = 8'h00; cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    chk("enable cyc at accept+1", 32'(cyc_o), 32'd1);
    chk("enable adr at accept+1", 32'(adr_o), 32'd0);
    chk("enable dat at accept+1", 32'(dat_o), 32'hC0);
    tick();
    chk("enable rsp_valid at accept+2", 32'(rsp_valid_o), 32'd1);
    chk("enable cyc dropped", 32'(cyc_o), 32'd0);
    $display("enable latency: rsp_valid=%0d status=%0d", rsp_valid_o, rsp_status_o);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;

    // timeout: response 20 cycles after WAIT_IRQ entry (the cycle after CMDR ack)
    ack_wait = 0; irq_delay = -1; clear_log();
    do_cmd(OP_START, 8'h00, 0, "timeout", st, dt);
    $display("timeout: status=%0d cycles_from_cmdr_ack=%0d cmdr_rd=%0d", st, rsp_at - cmdr_at, crd_n);
    chk("timeout latency", rsp_at - cmdr_at, 21);
    chk("timeout status", 32'(st), 32'd3);
    chk("timeout no cmdr read", crd_n, 0);

    // reset while waiting for irq: no response, back to idle
    ack_wait = 0; irq_delay = -1; clear_log();
    cmd_op_i = OP_START; cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    seen = 0;
    while (cmdr_n == 0 && seen < 20) begin tick(); seen++; end
    chk("rst_wait cmdr written", cmdr_n, 1);
    repeat (3) tick();
    rsp_ready_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rst_wait cyc", 32'(cyc_o), 32'd0);
    tick();
    chk("rst_wait cmd_ready", 32'(cmd_ready_o), 32'd1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rsp_valid_o) seen++;
    end
    chk("rst_wait no rsp", seen, 0);
    $display("reset in WAIT_IRQ: cmd_ready=%0d rsp_valid_cycles=%0d", cmd_ready_o, seen);

    // reset in the middle of a stalled bus access drops cyc/stb on that edge
    ack_wait = 40; irq_delay = 2; clear_log();
    cmd_op_i = OP_WRITE; cmd_data_i = 8'h5A; cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    chk("rst_bus cyc active", 32'(cyc_o), 32'd1);
    tick();
    rst_i = 1'b1;
    tick();
    chk("rst_bus cyc", 32'(cyc_o), 32'd0);
    chk("rst_bus stb", 32'(stb_o), 32'd0);
    rst_i = 1'b0;
    ack_wait = 0;
    tick();
    chk("rst_bus cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_bus no rsp", 32'(rsp_valid_o), 32'd0);
    $display("reset mid-access: cyc=%0d cmd_ready=%0d", cyc_o, cmd_ready_o);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
